// File: rtl/i2s_mic_rx_if.sv
// PCM sample bus between the I2S microphone receiver and its consumer.
// The receiver drives the master side; the sample buffer listens as slave.
interface i2s_mic_rx_if #(
    parameter int OUT_BITS = 16
);
    logic [OUT_BITS-1:0] pcm_out;
    logic                pcm_ready;

    modport master (
        output pcm_out,
        output pcm_ready
    );

    modport slave (
        input pcm_out,
        input pcm_ready
    );
endinterface

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for a MEMS microphone: generates SCK/WS, deserialises
// one channel of 24-in-32 data and emits a truncated signed PCM sample.
module i2s_mic_rx #(
    parameter int CLK_DIV   = 4,
    parameter int SLOT_BITS = 32,
    parameter int DATA_BITS = 24,
    parameter int OUT_BITS  = 16,
    parameter int CHANNEL   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         M_DATA,
    output logic         M_CLK,
    output logic         M_LRCLK,
    output logic         M_LRSEL,
    i2s_mic_rx_if.master pcm
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(2 * SLOT_BITS);

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT_LEN  = BW'(SLOT_BITS);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS);
    localparam logic          CH        = (CHANNEL != 0);

    logic [DW-1:0]        div_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 sck;
    logic                 ws;
    logic [DATA_BITS-2:0] sh;
    logic [OUT_BITS-1:0]  pcm_q;
    logic                 rdy_q;

    logic                 tick;
    logic                 slot;
    logic [BW-1:0]        pos;
    logic [BW-1:0]        bit_nxt;
    logic                 in_data;
    logic [DATA_BITS-1:0] sh_nxt;

    // Half-period boundary of SCK; rise vs fall is decided by the current level.
    assign tick    = (div_cnt == DIV_LAST);
    assign slot    = (bit_cnt >= SLOT_LEN);
    assign pos     = slot ? (bit_cnt - SLOT_LEN) : bit_cnt;
    assign bit_nxt = (bit_cnt == BIT_LAST) ? '0 : (bit_cnt + BW'(1));
    // Position 0 is the I2S delay bit; positions past the data are tri-stated.
    assign in_data = (slot == CH) && (pos != '0) && (pos <= DATA_LAST);
    assign sh_nxt  = {sh, M_DATA};

    // Divider, bit counter, WS generation and capture of the selected slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sck     <= 1'b0;
            ws      <= 1'b0;
            sh      <= '0;
            pcm_q   <= '0;
            rdy_q   <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sck     <= 1'b0;
            ws      <= 1'b0;
            sh      <= '0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (tick) begin
                div_cnt <= '0;
                sck     <= ~sck;
                if (!sck) begin
                    if (in_data) begin
                        sh <= sh_nxt[DATA_BITS-2:0];
                        if (pos == DATA_LAST) begin
                            pcm_q <= sh_nxt[DATA_BITS-1 -: OUT_BITS];
                            rdy_q <= 1'b1;
                        end
                    end
                end else begin
                    bit_cnt <= bit_nxt;
                    ws      <= (bit_nxt >= SLOT_LEN);
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    assign M_CLK         = sck;
    assign M_LRCLK       = ws;
    assign M_LRSEL       = CH;
    assign pcm.pcm_out   = pcm_q;
    assign pcm.pcm_ready = rdy_q;
endmodule
